// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - multi-CPU single-port RAM arbiter, data-over-instruction priority, round-robin per type
// Optional grant watchdog (TIMEOUT parameter, arb_err port) enabled by defining ARB_TIMEOUT_EN.
module ram_arbiter #(
    parameter int CPUS = 2
`ifdef ARB_TIMEOUT_EN
    , parameter int TIMEOUT = 255
`endif
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS-1:0][31:0] iaddr,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS-1:0][31:0] iload,
    output logic [CPUS-1:0][31:0] dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate
`ifdef ARB_TIMEOUT_EN
    , output logic               arb_err
`endif
);

    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
    // ramstate encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3
    localparam logic [1:0] RS_ACCESS = 2'd2;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   gcpu_q, gcpu_d;
    logic            gdata_q, gdata_d;
    logic [CW-1:0]   dptr_q, dptr_d;
    logic [CW-1:0]   iptr_q, iptr_d;

    logic [CPUS-1:0] dreq;
    logic            d_found, i_found;
    logic [CW-1:0]   d_win, i_win;

    logic            g_act, g_wen;
    logic [31:0]     g_addr, g_store;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_d;
`endif

    function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= CPUS) s = s - CPUS;
        return CW'(s);
    endfunction

    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

    // Round-robin search starting at each type's pointer
    always_comb begin
        dreq    = dREN | dWEN;
        d_found = 1'b0;
        d_win   = '0;
        i_found = 1'b0;
        i_win   = '0;
        for (int k = 0; k < CPUS; k++) begin
            if (!d_found && dreq[wrap_add(dptr_q, k)]) begin
                d_found = 1'b1;
                d_win   = wrap_add(dptr_q, k);
            end
            if (!i_found && iREN[wrap_add(iptr_q, k)]) begin
                i_found = 1'b1;
                i_win   = wrap_add(iptr_q, k);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gcpu_d   = gcpu_q;
        gdata_d  = gdata_q;
        dptr_d   = dptr_q;
        iptr_d   = iptr_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        g_act    = 1'b0;
        g_wen    = 1'b0;
        g_addr   = '0;
        g_store  = '0;
`ifdef ARB_TIMEOUT_EN
        tmo_d    = '0;
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (d_found) begin
                    state_d = GRANT;
                    gcpu_d  = d_win;
                    gdata_d = 1'b1;
                end else if (i_found) begin
                    state_d = GRANT;
                    gcpu_d  = i_win;
                    gdata_d = 1'b0;
                end
            end
            GRANT: begin
                if (gdata_q) begin
                    g_act   = dREN[gcpu_q] | dWEN[gcpu_q];
                    g_wen   = dWEN[gcpu_q];
                    g_addr  = daddr[gcpu_q];
                    g_store = dstore[gcpu_q];
                end else begin
                    g_act   = iREN[gcpu_q];
                    g_addr  = iaddr[gcpu_q];
                end
                if (!g_act) begin
                    // Requester withdrew: abandon without completion or pointer move
                    state_d = IDLE;
                end else begin
                    ramWEN   = g_wen;
                    ramREN   = ~g_wen;
                    ramaddr  = g_addr;
                    ramstore = g_store;
                    if (ramstate == RS_ACCESS) begin
                        state_d = IDLE;
                        if (gdata_q) begin
                            dwait[gcpu_q] = 1'b0;
                            dptr_d        = wrap_add(gcpu_q, 1);
                        end else begin
                            iwait[gcpu_q] = 1'b0;
                            iptr_d        = wrap_add(gcpu_q, 1);
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        // Stuck grant: drop it and skip past the requester
                        state_d = IDLE;
                        err_d   = 1'b1;
                        if (gdata_q) dptr_d = wrap_add(gcpu_q, 1);
                        else         iptr_d = wrap_add(gcpu_q, 1);
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (!nRST) begin
            iwait = '1;
            dwait = '1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            gcpu_q  <= '0;
            gdata_q <= 1'b0;
            dptr_q  <= '0;
            iptr_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            tmo_q   <= '0;
            arb_err <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gcpu_q  <= gcpu_d;
            gdata_q <= gdata_d;
            dptr_q  <= dptr_d;
            iptr_q  <= iptr_d;
`ifdef ARB_TIMEOUT_EN
            tmo_q   <= tmo_d;
            arb_err <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed table-driven bench for ram_arbiter (2 CPUs)
module tb_ram_arbiter;

    localparam logic [1:0] F = 2'd0, B = 2'd1, A = 2'd2, E = 2'd3;
    localparam logic [31:0] S0 = 32'hAAAA0000, S1 = 32'h12345678, LD = 32'hDEADBEEF;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [1:0]       iREN, dREN, dWEN;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait;
    logic [1:0][31:0] iload, dload;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;
`ifdef ARB_TIMEOUT_EN
    logic             arb_err;
`endif

    int checks = 0;
    int failures = 0;

    ram_arbiter #(
        .CPUS(2)
`ifdef ARB_TIMEOUT_EN
        , .TIMEOUT(4)
`endif
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
`ifdef ARB_TIMEOUT_EN
        , .arb_err(arb_err)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        nrst;
        logic [1:0]  iren, dren, dwen, rs;
        logic        eren, ewen;
        logic [31:0] eaddr, estore;
        logic [1:0]  eiw, edw;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(input logic nr, input logic [1:0] ir, input logic [1:0] dr,
                               input logic [1:0] dw, input logic [1:0] r, input logic er,
                               input logic ew, input logic [31:0] ea, input logic [31:0] es,
                               input logic [1:0] iw, input logic [1:0] dwt);
        vec_t t;
        t.nrst = nr; t.iren = ir; t.dren = dr; t.dwen = dw; t.rs = r;
        t.eren = er; t.ewen = ew; t.eaddr = ea; t.estore = es; t.eiw = iw; t.edw = dwt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic nr, input logic [1:0] ir, input logic [1:0] dr,
                         input logic [1:0] dw, input logic [1:0] r);
        @(negedge CLK);
        nRST = nr; iREN = ir; dREN = dr; dWEN = dw; ramstate = r;
        #2;
    endtask

    initial begin
        iaddr[0] = 32'h200; iaddr[1] = 32'h300;
        daddr[0] = 32'h100; daddr[1] = 32'h180;
        dstore[0] = S0;     dstore[1] = S1;
        ramload = LD;
        nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; ramstate = F;
        repeat (2) @(posedge CLK);

        tv.push_back(v(0, 2'b00, 2'b00, 2'b00, F, 0, 0, 0,      0,  2'b11, 2'b11));
        // single data read completing on first grant cycle
        tv.push_back(v(1, 2'b00, 2'b01, 2'b00, A, 0, 0, 0,      0,  2'b11, 2'b11));
        tv.push_back(v(1, 2'b00, 2'b01, 2'b00, A, 1, 0, 32'h100, S0, 2'b11, 2'b10));
        // data write beats simultaneous instruction fetch
        tv.push_back(v(1, 2'b01, 2'b00, 2'b10, F, 0, 0, 0,      0,  2'b11, 2'b11));
        tv.push_back(v(1, 2'b01, 2'b00, 2'b10, A, 0, 1, 32'h180, S1, 2'b11, 2'b01));
        tv.push_back(v(1, 2'b01, 2'b00, 2'b00, F, 0, 0, 0,      0,  2'b11, 2'b11));
        tv.push_back(v(1, 2'b01, 2'b00, 2'b00, A, 1, 0, 32'h200, 0,  2'b10, 2'b11));
        // both CPUs stream data reads, 2 BUSY then ACCESS
        tv.push_back(v(1, 2'b00, 2'b11, 2'b00, B, 0, 0, 0,      0,  2'b11, 2'b11));
        tv.push_back(v(1, 2'b00, 2'b11, 2'b00, B, 1, 0, 32'h100, S0, 2'b11, 2'b11));
        tv.push_back(v(1, 2'b00, 2'b11, 2'b00, B, 1, 0, 32'h100, S0, 2'b11, 2'b11));
        tv.push_back(v(1, 2'b00, 2'b11, 2'b00, A, 1, 0, 32'h100, S0, 2'b11, 2'b10));
        tv.push_back(v(1, 2'b00, 2'b11, 2'b00, B, 0, 0, 0,      0,  2'b11, 2'b11));
        tv.push_back(v(1, 2'b00, 2'b11, 2'b00, B, 1, 0, 32'h180, S1, 2'b11, 2'b11));
        tv.push_back(v(1, 2'b00, 2'b11, 2'b00, B, 1, 0, 32'h180, S1, 2'b11, 2'b11));
        tv.push_back(v(1, 2'b00, 2'b11, 2'b00, A, 1, 0, 32'h180, S1, 2'b11, 2'b01));
        tv.push_back(v(1, 2'b00, 2'b11, 2'b00, B, 0, 0, 0,      0,  2'b11, 2'b11));
        tv.push_back(v(1, 2'b00, 2'b11, 2'b00, A, 1, 0, 32'h100, S0, 2'b11, 2'b10));
        // CPU1 fetch withdrawn mid-grant; iptr must stay on CPU1
        tv.push_back(v(1, 2'b10, 2'b00, 2'b00, F, 0, 0, 0,      0,  2'b11, 2'b11));
        tv.push_back(v(1, 2'b10, 2'b00, 2'b00, B, 1, 0, 32'h300, 0,  2'b11, 2'b11));
        tv.push_back(v(1, 2'b00, 2'b00, 2'b00, B, 0, 0, 0,      0,  2'b11, 2'b11));
        tv.push_back(v(1, 2'b11, 2'b00, 2'b00, F, 0, 0, 0,      0,  2'b11, 2'b11));
        tv.push_back(v(1, 2'b11, 2'b00, 2'b00, A, 1, 0, 32'h300, 0,  2'b01, 2'b11));
        tv.push_back(v(1, 2'b11, 2'b00, 2'b00, F, 0, 0, 0,      0,  2'b11, 2'b11));
        tv.push_back(v(1, 2'b11, 2'b00, 2'b00, A, 1, 0, 32'h200, 0,  2'b10, 2'b11));
        // ERROR and FREE hold the grant
        tv.push_back(v(1, 2'b00, 2'b01, 2'b00, E, 0, 0, 0,      0,  2'b11, 2'b11));
        tv.push_back(v(1, 2'b00, 2'b01, 2'b00, E, 1, 0, 32'h100, S0, 2'b11, 2'b11));
        tv.push_back(v(1, 2'b00, 2'b01, 2'b00, F, 1, 0, 32'h100, S0, 2'b11, 2'b11));
        tv.push_back(v(1, 2'b00, 2'b01, 2'b00, A, 1, 0, 32'h100, S0, 2'b11, 2'b10));
        // dREN and dWEN together: write wins
        tv.push_back(v(1, 2'b00, 2'b10, 2'b10, F, 0, 0, 0,      0,  2'b11, 2'b11));
        tv.push_back(v(1, 2'b00, 2'b10, 2'b10, A, 0, 1, 32'h180, S1, 2'b11, 2'b01));
        tv.push_back(v(1, 2'b00, 2'b00, 2'b00, F, 0, 0, 0,      0,  2'b11, 2'b11));

        foreach (tv[i]) begin
            drive(tv[i].nrst, tv[i].iren, tv[i].dren, tv[i].dwen, tv[i].rs);
            chk($sformatf("v%0d ramREN", i),   32'(ramREN),   32'(tv[i].eren));
            chk($sformatf("v%0d ramWEN", i),   32'(ramWEN),   32'(tv[i].ewen));
            chk($sformatf("v%0d ramaddr", i),  ramaddr,       tv[i].eaddr);
            chk($sformatf("v%0d ramstore", i), ramstore,      tv[i].estore);
            chk($sformatf("v%0d iwait", i),    32'(iwait),    32'(tv[i].eiw));
            chk($sformatf("v%0d dwait", i),    32'(dwait),    32'(tv[i].edw));
            if (tv[i].edw != 2'b11)
                chk($sformatf("v%0d dload", i), dload[tv[i].edw[0] ? 1 : 0], LD);
            if (tv[i].eiw != 2'b11)
                chk($sformatf("v%0d iload", i), iload[tv[i].eiw[0] ? 1 : 0], LD);
        end

        // reset during a BUSY grant to CPU1 with dptr=1
        drive(1, 2'b00, 2'b11, 2'b00, A);
        drive(1, 2'b00, 2'b11, 2'b00, A);
        drive(1, 2'b00, 2'b11, 2'b00, B);
        drive(1, 2'b00, 2'b11, 2'b00, B);
        chk("rst pre ramaddr", ramaddr, 32'h180);
        chk("rst pre ramREN", 32'(ramREN), 32'd1);
        drive(0, 2'b00, 2'b11, 2'b00, B);
        chk("rst dwait", 32'(dwait), 32'h3);
        chk("rst iwait", 32'(iwait), 32'h3);
        drive(0, 2'b00, 2'b11, 2'b00, B);
        chk("rst ramREN", 32'(ramREN), 32'd0);
        chk("rst ramWEN", 32'(ramWEN), 32'd0);
        drive(1, 2'b00, 2'b11, 2'b00, B);
        drive(1, 2'b00, 2'b11, 2'b00, B);
        chk("rst dptr", ramaddr, 32'h100);
        drive(1, 2'b11, 2'b00, 2'b00, B);
        chk("drop ramREN", 32'(ramREN), 32'd0);
        drive(1, 2'b11, 2'b00, 2'b00, B);
        drive(1, 2'b11, 2'b00, 2'b00, B);
        chk("rst iptr", ramaddr, 32'h200);
        begin
            int n;
            n = 0;
            drive(1, 2'b11, 2'b00, 2'b00, B);
            while (iwait[0] !== 1'b0 && n < 8) begin
                drive(1, 2'b11, 2'b00, 2'b00, A);
                n++;
            end
            chk("fetch done", 32'(iwait[0]), 32'd0);
        end

`ifdef ARB_TIMEOUT_EN
        drive(0, 2'b00, 2'b00, 2'b00, F);
        drive(1, 2'b00, 2'b11, 2'b00, B);
        chk("tmo idle err", 32'(arb_err), 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 2'b00, 2'b11, 2'b00, B);
            chk($sformatf("tmo g%0d addr", k), ramaddr, 32'h100);
            chk($sformatf("tmo g%0d err", k), 32'(arb_err), 32'd0);
        end
        drive(1, 2'b00, 2'b11, 2'b00, B);
        chk("tmo err pulse", 32'(arb_err), 32'd1);
        chk("tmo idle ramREN", 32'(ramREN), 32'd0);
        drive(1, 2'b00, 2'b11, 2'b00, B);
        chk("tmo next cpu", ramaddr, 32'h180);
        chk("tmo err clear", 32'(arb_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
